// File: rtl/count_ctrl_debounce_pkg.sv
// -----------------------------------------------------------------------------
// count_ctrl_debounce_pkg
// Shared constants for the counter control front end:
//   - debounce FSM state encodings (kept as plain 2-bit constants so that
//     legacy netlists and probes see the same codes)
//   - default debounce length and counter width
// -----------------------------------------------------------------------------
package count_ctrl_debounce_pkg;

  localparam logic [1:0] ST_LOW  = 2'd0;
  localparam logic [1:0] ST_RISE = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_FALL = 2'd3;

  localparam int DB_CYCLES_DEF = 4;
  localparam int DB_W_DEF      = 20;

endpackage

// File: rtl/count_ctrl_debounce_if.sv
// -----------------------------------------------------------------------------
// count_ctrl_debounce_if
// Groups the button inputs and the counter control outputs.
//   btn_step : raw asynchronous step button, active-high
//   btn_dir  : raw asynchronous direction button, active-high
//   count_en : one-cycle pulse per accepted step press
//   up_down  : direction level (1 = up, 0 = down)
// master : the side that owns the buttons and consumes the controls
// slave  : the debounce block itself
// -----------------------------------------------------------------------------
interface count_ctrl_debounce_if;
  import count_ctrl_debounce_pkg::*;

  logic btn_step;
  logic btn_dir;
  logic count_en;
  logic up_down;

  modport master (output btn_step, output btn_dir, input count_en, input up_down);
  modport slave  (input btn_step, input btn_dir, output count_en, output up_down);

endinterface

// File: rtl/count_ctrl_debounce_chan.sv
// -----------------------------------------------------------------------------
// count_ctrl_debounce_chan
// One debounce channel: 2-flop synchronizer, 4-state debounce FSM and a
// stability counter.
//   clk          : system clock
//   rst          : synchronous active-high reset
//   btn_i        : raw asynchronous button
//   stable_o     : debounced button level
//   rise_pulse_o : high for the single cycle in which a press is accepted
//                  (decoded from the current state, so the consumer's register
//                  captures it on the same edge the FSM enters ST_HIGH)
// -----------------------------------------------------------------------------
module count_ctrl_debounce_chan
  import count_ctrl_debounce_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int DB_W      = DB_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic stable_o,
  output logic rise_pulse_o
);

  localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic [1:0]      state_q, state_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            stable_q, stable_d;
  logic            rise_s;

  // Debounce next-state: any mismatching sample aborts a pending transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_s   = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (sync2_q) begin
          state_d = ST_RISE;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = ST_LOW;
        end
      end
      ST_RISE: begin
        if (!sync2_q) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_HIGH;
          cnt_d    = '0;
          stable_d = 1'b1;
          rise_s   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!sync2_q) begin
          state_d = ST_FALL;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = ST_HIGH;
        end
      end
      ST_FALL: begin
        if (sync2_q) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Release is accepted silently: no pulse on the falling side.
          state_d  = ST_LOW;
          cnt_d    = '0;
          stable_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d  = ST_LOW;
        cnt_d    = '0;
        stable_d = 1'b0;
      end
    endcase
  end

  // Synchronizer, FSM state, counter and stable level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= ST_LOW;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o     = stable_q;
  assign rise_pulse_o = rise_s;

endmodule

// File: rtl/count_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// count_ctrl_debounce
// Control stage ahead of the mod-n up/down counter. Debounces the step and
// direction buttons and produces:
//   bus.count_en : registered one-cycle pulse per accepted step press
//   bus.up_down  : registered direction level, toggled per accepted dir press
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : count_ctrl_debounce_if.slave (buttons in, counter controls out)
// -----------------------------------------------------------------------------
module count_ctrl_debounce
  import count_ctrl_debounce_pkg::*;
#(
  parameter int   DB_CYCLES   = DB_CYCLES_DEF,
  parameter int   DB_W        = DB_W_DEF,
  parameter logic UP_DOWN_RST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  count_ctrl_debounce_if.slave  bus
);

  logic step_stable_s;
  logic step_rise_s;
  logic dir_stable_s;
  logic dir_rise_s;
  logic unused_stable_s;
  logic count_en_q;
  logic up_down_q;

  count_ctrl_debounce_chan #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) u_step_chan (
    .clk          (clk),
    .rst          (rst),
    .btn_i        (bus.btn_step),
    .stable_o     (step_stable_s),
    .rise_pulse_o (step_rise_s)
  );

  count_ctrl_debounce_chan #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) u_dir_chan (
    .clk          (clk),
    .rst          (rst),
    .btn_i        (bus.btn_dir),
    .stable_o     (dir_stable_s),
    .rise_pulse_o (dir_rise_s)
  );

  // Debounced levels are only needed for edge detection inside the channels.
  assign unused_stable_s = step_stable_s & dir_stable_s;

  // Output registers: step pulse copy and direction toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_en_q <= 1'b0;
      up_down_q  <= UP_DOWN_RST;
    end else begin
      count_en_q <= step_rise_s;
      up_down_q  <= up_down_q ^ dir_rise_s;
    end
  end

  assign bus.count_en = count_en_q;
  assign bus.up_down  = up_down_q;

endmodule
